fdiv_seq: RTL and testbench

FDIV_SEQ -- requirements
Module: fdiv_seq

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fdiv_mant.sv | 64 ++++++
 rtl/fdiv_seq.sv | 136 +++++++++++++
 tb/tb_fdiv_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions.
// Holds IEEE-754 single field widths, the exponent bias and the all-ones
// exponent, and the state encoding used by the sequential divider FSM.
package fpu_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } fdiv_state_e;

endpackage

// File: rtl/fdiv_mant.sv
// Restoring mantissa divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst        clock, synchronous active-high reset (aborts iteration)
//   start           load dividend/divisor and begin QBITS iterations
//   dividend        {1,m1} with hidden bit
//   divisor         {1,m2} with hidden bit
//   busy            iterations remaining
//   last            the current cycle performs the final iteration
//   quot            quotient; quot[QBITS-1] has weight 1
module fdiv_mant
  import fpu_pkg::*;
#(
  parameter int unsigned QBITS = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             busy,
  output logic             last,
  output logic [QBITS-1:0] quot
);

  localparam int unsigned CNT_W = $clog2(QBITS + 1);
  localparam int unsigned REM_W = MAN_W + 3;

  logic [REM_W-1:0] rem;
  logic [MAN_W:0]   dvs;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] dvs_ext;
  logic [REM_W-1:0] diff;

  assign dvs_ext = {2'b00, dvs};
  assign diff    = rem - dvs_ext;
  assign busy    = (cnt != '0);
  assign last    = (cnt == CNT_W'(1));

  // Remainder stays below 2*divisor, so one guard bit above the shifted
  // remainder suffices; the top bit of diff is never kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dvs  <= '0;
      quot <= '0;
      cnt  <= '0;
    end else if (start) begin
      rem  <= {2'b00, dividend};
      dvs  <= divisor;
      quot <= '0;
      cnt  <= CNT_W'(QBITS);
    end else if (busy) begin
      if (rem >= dvs_ext) begin
        rem  <= {diff[REM_W-2:0], 1'b0};
        quot <= {quot[QBITS-2:0], 1'b1};
      end else begin
        rem  <= {rem[REM_W-2:0], 1'b0};
        quot <= {quot[QBITS-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider (normalized operands only,
// truncating). Special operands finish immediately; otherwise the mantissa
// quotient is produced by fdiv_mant and normalized in one extra cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   x1, x2, in_valid      dividend, divisor, operand strobe
//   in_ready              high only while idle
//   y, ovf, out_valid     quotient, forced-to-infinity flag, result strobe
//   out_ready             consumer accepts the result
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int unsigned QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  fdiv_state_e state, state_n;

  logic             sy;
  logic [EXP_W-1:0] e1, e2;
  logic [31:0]      y_n;
  logic             ovf_n;

  logic [EXP_W-1:0] e1_in, e2_in;
  logic             sy_in;
  logic             spec_inf, spec_zero;
  logic             accept, start;

  logic             mant_busy, mant_last;
  logic [QBITS-1:0] quot;

  logic signed [9:0] exp_n;
  logic [MAN_W-1:0]  mant_n;

  assign e1_in     = x1[30:23];
  assign e2_in     = x2[30:23];
  assign sy_in     = x1[31] ^ x2[31];
  assign spec_inf  = (e2_in == '0) || (e1_in == EXP_MAX);
  assign spec_zero = (e1_in == '0) || (e2_in == EXP_MAX);
  assign accept    = in_valid && (state == IDLE);
  assign start     = accept && !spec_inf && !spec_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  fdiv_mant #(.QBITS(QBITS)) u_mant (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend ({1'b1, x1[MAN_W-1:0]}),
    .divisor  ({1'b1, x2[MAN_W-1:0]}),
    .busy     (mant_busy),
    .last     (mant_last),
    .quot     (quot)
  );

  // Quotient lies in (0.5,2): a set integer bit means no left shift is
  // needed and the biased exponent gains one.
  assign exp_n  = $signed({2'b00, e1}) - $signed({2'b00, e2})
                + (quot[QBITS-1] ? 10'sd127 : 10'sd126);
  assign mant_n = quot[QBITS-1] ? quot[QBITS-2 -: MAN_W] : quot[QBITS-3 -: MAN_W];

  always_comb begin
    state_n = state;
    y_n     = y;
    ovf_n   = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (spec_inf) begin
            y_n     = {sy_in, EXP_MAX, {MAN_W{1'b0}}};
            ovf_n   = 1'b1;
            state_n = DONE;
          end else if (spec_zero) begin
            y_n     = {sy_in, 31'b0};
            ovf_n   = 1'b0;
            state_n = DONE;
          end else begin
            state_n = DIV;
          end
        end
      end
      DIV: begin
        if (mant_last || !mant_busy) state_n = NORM;
      end
      NORM: begin
        if (exp_n <= 10'sd0) begin
          y_n   = {sy, 31'b0};
          ovf_n = 1'b0;
        end else if (exp_n >= 10'sd255) begin
          y_n   = {sy, EXP_MAX, {MAN_W{1'b0}}};
          ovf_n = 1'b1;
        end else begin
          y_n   = {sy, exp_n[EXP_W-1:0], mant_n};
          ovf_n = 1'b0;
        end
        state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      ovf   <= 1'b0;
      sy    <= 1'b0;
      e1    <= '0;
      e2    <= '0;
    end else begin
      state <= state_n;
      y     <= y_n;
      ovf   <= ovf_n;
      if (accept) begin
        sy <= sy_in;
        e1 <= e1_in;
        e2 <= e2_in;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: vector table driven through a
// scoreboard, plus backpressure, reset-abort and reset-priority sequences.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1, x2, y;
  logic        in_valid, in_ready, ovf, out_valid, out_ready;

  always #5 clk = ~clk;

  fdiv_seq #(.QBITS(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ey;
    logic        eovf;
    int          elat;
  } vec_t;

  typedef struct {
    logic [31:0] ey;
    logic        eovf;
    int          elat;
    int          acc;
  } exp_t;

  localparam int LAT_N = 26;  // edges after accept, normal path
  localparam int LAT_S = 0;   // special: valid right after the accepting edge

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ey, input logic eovf, input int elat);
    int   n;
    exp_t e;
    n = 0;
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    e.ey = ey; e.eovf = eovf; e.elat = elat; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    x1 = $urandom;
    x2 = $urandom;
  endtask

  // Waits for the result, compares, optionally stalls 'hold' cycles, then
  // completes the handshake and checks the block returned to idle.
  task automatic receive(input int hold);
    int          n;
    exp_t        e;
    logic [31:0] y0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("result_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("unexpected_result", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("y", y, e.ey);
    chk("ovf", 32'(ovf), 32'(e.eovf));
    chk("latency", 32'(cyc - e.acc), 32'(e.elat));
    if (hold > 0) begin
      out_ready = 1'b0;
      y0 = y;
      repeat (hold) @(negedge clk);
      chk("hold_y", y, y0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    int   seen;

    vt[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT_N};
    vt[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, LAT_N};
    vt[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, LAT_S};
    vt[3]  = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, LAT_N};
    vt[4]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, LAT_N};
    vt[5]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, LAT_S};
    vt[6]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, LAT_S};
    vt[7]  = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, LAT_S};
    vt[8]  = '{32'hC0400000, 32'h3FC00000, 32'hC0000000, 1'b0, LAT_N};
    vt[9]  = '{32'h40490FDB, 32'h3F800000, 32'h40490FDB, 1'b0, LAT_N};
    vt[10] = '{32'h00800000, 32'h3F800001, 32'h00000000, 1'b0, LAT_N};
    vt[11] = '{32'h7F000000, 32'h3F7FFFFF, 32'h7F000000, 1'b0, LAT_N};
    vt[12] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAA, 1'b0, LAT_N};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1 = '0; x2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      send(vt[i].a, vt[i].b, vt[i].ey, vt[i].eovf, vt[i].elat);
      receive(0);
    end

    // Backpressure, ignored in_valid while busy, then back-to-back op.
    out_ready = 1'b0;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT_N);
    in_valid = 1'b1;
    x1 = 32'h3F800000;
    x2 = 32'h00000000;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    receive(10);
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, LAT_N);
    receive(0);

    // Reset during DIV cycle 12 aborts the operation.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT_N);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    send(32'hC0400000, 32'h3FC00000, 32'hC0000000, 1'b0, LAT_N);
    receive(0);

    // Reset wins over a simultaneous special-case handshake.
    x1 = 32'hBF800000;
    x2 = 32'h00000000;
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    chk("rstprio_out_valid", 32'(out_valid), 32'd0);
    chk("rstprio_in_ready", 32'(in_ready), 32'd1);
    send(32'h40000000, 32'h40400000, 32'h3F2AAAAA, 1'b0, LAT_N);
    receive(0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
